// File: rtl/ym_pkg.sv
// Shared constants and types for the YM2151 timer block.
package ym_pkg;

    localparam logic [7:0] REG_CLKA1 = 8'h10;
    localparam logic [7:0] REG_CLKA2 = 8'h11;
    localparam logic [7:0] REG_CLKB  = 8'h12;
    localparam logic [7:0] REG_CTRL  = 8'h14;

    // Bit positions inside control register 0x14 (bit 6 has no function).
    localparam int CTRL_LOAD_A    = 0;
    localparam int CTRL_LOAD_B    = 1;
    localparam int CTRL_IRQEN_A   = 2;
    localparam int CTRL_IRQEN_B   = 3;
    localparam int CTRL_F_RESET_A = 4;
    localparam int CTRL_F_RESET_B = 5;
    localparam int CTRL_CSM       = 7;

    typedef enum logic {T_STOP, T_RUN} tstate_t;

endpackage

// File: rtl/ym_timer_chan.sv
// One interval-timer channel: W-bit up-counter with a STOP/RUN state machine.
module ym_timer_chan
    import ym_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         load_start,
    input  logic         load_stop,
    input  logic [W-1:0] n,
    output logic         ovf,
    output tstate_t      state
);

    tstate_t        state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           cnt_full;

    assign cnt_full = (cnt_q == {W{1'b1}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Overflow uses the pre-write state, so a same-cycle stop still counts it.
        ovf     = (state_q == T_RUN) && tick && cnt_full;
        case (state_q)
            T_STOP: begin
                if (load_start) begin
                    state_d = T_RUN;
                    cnt_d   = n;
                end
            end
            T_RUN: begin
                if (tick) begin
                    cnt_d = cnt_full ? n : cnt_q + W'(1);
                end
                if (load_stop) begin
                    state_d = T_STOP;
                end
            end
            default: begin
                state_d = T_STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= T_STOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ym_timer_unit.sv
// YM2151 timers A and B: shared prescalers, sticky overflow flags and CSM key-on.
module ym_timer_unit
    import ym_pkg::*;
#(
    parameter int PRESC_A      = 64,
    parameter int PRESC_B_MULT = 16
) (
    input  logic       phiM,
    input  logic       IC_b,
    input  logic [9:0] clka,
    input  logic [7:0] clkb,
    input  logic       ctrl_wr,
    input  logic [7:0] ctrl_wdata,
    output logic       TM_1,
    output logic       TM_2,
    output logic       csm_kon,
    output tstate_t    dbg_state_a,
    output tstate_t    dbg_state_b
);

    localparam int PA_W = (PRESC_A > 1) ? $clog2(PRESC_A) : 1;
    localparam int PB_W = (PRESC_B_MULT > 1) ? $clog2(PRESC_B_MULT) : 1;

    // ctrl_wr is a bare strobe with no back-pressure: ctrl_wdata is consumed
    // on every rising phiM where ctrl_wr=1 and is ignored otherwise.
    logic [PA_W-1:0] presc_a_q, presc_a_d;
    logic [PB_W-1:0] presc_b_q, presc_b_d;
    logic            tick_a, tick_b;
    logic            irqen_a_q, irqen_a_d;
    logic            irqen_b_q, irqen_b_d;
    logic            csm_q, csm_d;
    logic            tm1_q, tm1_d;
    logic            tm2_q, tm2_d;
    logic            csm_kon_q, csm_kon_d;
    logic            ovf_a, ovf_b;
    logic            ctrl_unused;

    assign ctrl_unused = ctrl_wdata[6];

    assign tick_a = (presc_a_q == PA_W'(PRESC_A - 1));
    assign tick_b = tick_a && (presc_b_q == PB_W'(PRESC_B_MULT - 1));

    always_comb begin
        presc_a_d = tick_a ? '0 : presc_a_q + PA_W'(1);
        presc_b_d = presc_b_q;
        if (tick_a) begin
            presc_b_d = tick_b ? '0 : presc_b_q + PB_W'(1);
        end
    end

    ym_timer_chan #(.W(10)) u_chan_a (
        .clk        (phiM),
        .rst_n      (IC_b),
        .tick       (tick_a),
        .load_start (ctrl_wr && ctrl_wdata[CTRL_LOAD_A]),
        .load_stop  (ctrl_wr && !ctrl_wdata[CTRL_LOAD_A]),
        .n          (clka),
        .ovf        (ovf_a),
        .state      (dbg_state_a)
    );

    ym_timer_chan #(.W(8)) u_chan_b (
        .clk        (phiM),
        .rst_n      (IC_b),
        .tick       (tick_b),
        .load_start (ctrl_wr && ctrl_wdata[CTRL_LOAD_B]),
        .load_stop  (ctrl_wr && !ctrl_wdata[CTRL_LOAD_B]),
        .n          (clkb),
        .ovf        (ovf_b),
        .state      (dbg_state_b)
    );

    always_comb begin
        irqen_a_d = irqen_a_q;
        irqen_b_d = irqen_b_q;
        csm_d     = csm_q;
        if (ctrl_wr) begin
            irqen_a_d = ctrl_wdata[CTRL_IRQEN_A];
            irqen_b_d = ctrl_wdata[CTRL_IRQEN_B];
            csm_d     = ctrl_wdata[CTRL_CSM];
        end
        // Set beats clear so an overflow landing on a flag-reset write is kept.
        tm1_d = tm1_q;
        if (ovf_a && irqen_a_q) begin
            tm1_d = 1'b1;
        end else if (ctrl_wr && ctrl_wdata[CTRL_F_RESET_A]) begin
            tm1_d = 1'b0;
        end
        tm2_d = tm2_q;
        if (ovf_b && irqen_b_q) begin
            tm2_d = 1'b1;
        end else if (ctrl_wr && ctrl_wdata[CTRL_F_RESET_B]) begin
            tm2_d = 1'b0;
        end
        csm_kon_d = ovf_a && csm_q;
    end

    always_ff @(posedge phiM) begin
        if (!IC_b) begin
            presc_a_q <= '0;
            presc_b_q <= '0;
            irqen_a_q <= 1'b0;
            irqen_b_q <= 1'b0;
            csm_q     <= 1'b0;
            tm1_q     <= 1'b0;
            tm2_q     <= 1'b0;
            csm_kon_q <= 1'b0;
        end else begin
            presc_a_q <= presc_a_d;
            presc_b_q <= presc_b_d;
            irqen_a_q <= irqen_a_d;
            irqen_b_q <= irqen_b_d;
            csm_q     <= csm_d;
            tm1_q     <= tm1_d;
            tm2_q     <= tm2_d;
            csm_kon_q <= csm_kon_d;
        end
    end

    assign TM_1    = tm1_q;
    assign TM_2    = tm2_q;
    assign csm_kon = csm_kon_q;

endmodule

// File: doc/ym_timer_unit.md
Name: ym_timer_unit

Overview:
- Implements the two YM2151 interval timers (A: 10-bit, B: 8-bit) and sits directly upstream of the register file.
- Consumes the timer load values (regs 0x10–0x12) and the write of control reg 0x14.
- Produces the timer overflow flags TM_1/TM_2. The register file mirrors these into status bits [1:0] and turns them into IRQ_b.
- Also issues the CSM key-on pulse on Timer A overflow.

Parameters:
- PRESC_A, 64, phiM cycles per Timer A tick (fixed 64 in silicon; reduced only for simulation speed).
- PRESC_B_MULT, 16, Timer A ticks per Timer B tick (B tick = PRESC_A*PRESC_B_MULT = 1024 phiM cycles).

Ports:
- phiM  in  1  Sole clock, 3.579545 MHz. One clock; reset is synchronous and active-low.
- IC_b  in  1  Synchronous active-low reset, sampled on rising phiM.
- clka  in  10  Timer A load value NA = {reg10[7:0], reg11[1:0]}, level.
- clkb  in  8  Timer B load value NB = reg12, level.
- ctrl_wr  in  1  One-cycle strobe: reg 0x14 written this cycle.
- ctrl_wdata  in  8  Data written to 0x14, valid with ctrl_wr.
- TM_1  out  1  Timer A flag (sticky).
- TM_2  out  1  Timer B flag (sticky).
- csm_kon  out  1  One-cycle pulse on Timer A overflow while CSM=1.

Behaviour:
- Reg 0x14 fields: [0] LOAD_A, [1] LOAD_B, [2] IRQEN_A, [3] IRQEN_B, [4] F_RESET_A, [5] F_RESET_B, [7] CSM; [6] ignored.
- On ctrl_wr, latch LOAD_x, IRQEN_x and CSM. F_RESET_x are not stored; they act only in the cycle of ctrl_wr.
- Reset (IC_b=0 at a rising edge): prescalers, counters, latched control bits, TM_1, TM_2 and csm_kon all go to 0. Reset mid-count abandons the count; no overflow is issued.
- Prescaler A is free-running from reset and is never restarted by LOAD. tick_a is asserted for 1 cycle every PRESC_A cycles.
- Prescaler B counts tick_a modulo PRESC_B_MULT, also free-running. tick_b is asserted for 1 cycle.
- Channel state machine (per timer): STOP, RUN.
  - STOP→RUN: on a ctrl_wr with LOAD_x=1 while in STOP. The counter is loaded with N (clka/clkb value at that cycle).
  - RUN→STOP: on a ctrl_wr with LOAD_x=0. The counter holds its value; no overflow is issued.
  - ctrl_wr with LOAD_x=1 while already in RUN does not reload; the counter continues.
- In RUN, each tick increments the counter. On a tick while counter == all-ones:
  - overflow pulse (1 cycle, same cycle as the tick);
  - counter reloads with the current N.
  - Period = (2^W − N) ticks, W = 10/8. N = all-ones gives 1 tick. N = 0 gives 2^W ticks.
- Changes to clka/clkb while running take effect only at the next reload.
- Flag TM_x: set on a cycle with overflow_x and IRQEN_x=1, visible the next cycle. Cleared by ctrl_wr with F_RESET_x=1.
  - Simultaneous set and clear: set wins, so no event is lost.
  - An overflow with IRQEN_x=0 does not set the flag; an already-set flag stays set.
  - Clearing IRQEN does not clear the flag.
- csm_kon: registered; high in the cycle after overflow_a when the latched CSM=1. Independent of IRQEN_A.
- ctrl_wr and an overflow in the same cycle: the overflow is evaluated with the control bits latched before the write.

Decomposition:
- Package ym_pkg holds:
  - reg address constants (REG_CLKA1=8'h10, REG_CLKA2=8'h11, REG_CLKB=8'h12, REG_CTRL=8'h14);
  - reg 0x14 bit-index constants;
  - typedef enum logic {T_STOP, T_RUN} tstate_t.
- Sub-module ym_timer_chan #(W) contains one counter with its STOP/RUN state machine. Inputs: tick, load_start, load_stop, n[W-1:0]. Output: ovf. It is instantiated twice (W=10, W=8).
- Prescalers, flags and csm_kon logic live in the top.

Test Plan:
- Reset: assert IC_b=0 for 3 cycles while mid-count -> TM_1=TM_2=csm_kon=0; counters stopped; no overflow within 2000 cycles after release.
- Timer A: clka=1020, write 0x14=8'h05 -> TM_1 rises; after clearing with 0x14=8'h15, successive flag rises are exactly 256 phiM cycles apart (4 ticks × 64).
- Timer B: clkb=8'hFE, write 0x14=8'h0A -> steady-state overflows every 2048 cycles; TM_2 set; TM_1 stays 0.
- IRQ gating: clka=1023, 0x14=8'h01 (IRQEN_A=0) -> overflows every 64 cycles, TM_1 stays 0. Then write 8'h05 -> TM_1=1 one cycle after the next overflow.
- Flag clear race: issue ctrl_wr 8'h15 in the exact cycle of overflow_a -> TM_1 remains 1. Issue it one cycle later -> TM_1=0 until the next overflow.
- CSM + stop: 0x14=8'h81, clka=1023 -> csm_kon is a 1-cycle pulse every 64 cycles, TM_1=0. Write 8'h80 -> no further pulses; counter holds.
